serial_compare_sequencer: RTL and testbench

//  Accepts a pair of WIDTH-bit unsigned operands over a valid/ready handshake.

---
 rtl/serial_compare_sequencer.sv | 104 ++++++++++
 tb/tb_serial_compare_sequencer.sv | 167 ++++++++++++++++
 2 files changed

// File: rtl/serial_compare_sequencer.sv
// serial_compare_sequencer: feeds a WIDTH-bit operand pair MSB-first into a bit-serial comparator and returns a one-hot lt/eq/gt result
//
// Ports:
//   clk_i, rst_ni               clock (rising edge), asynchronous active-low reset
//   in_valid_i/in_ready_o       operand handshake; in_ready_o is high only while idle
//   in_a_i, in_b_i              unsigned operands, captured at acceptance
//   out_valid_o/out_ready_i     result handshake; result held stable until taken
//   res_lt_o/res_eq_o/res_gt_o  one-hot compare result, zero unless out_valid_o
//   res_bits_o                  bit pairs fed to the core for this result
//   busy_o                      high whenever not idle
//
// Build option: SERIAL_CMP_EARLY_EXIT_EN ends the shift phase at the first differing bit pair.
module serial_compare_sequencer #(
  parameter int WIDTH = 8,
  parameter int CNT_W = $clog2(WIDTH + 1)
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             in_valid_i,
  output logic             in_ready_o,
  input  logic [WIDTH-1:0] in_a_i,
  input  logic [WIDTH-1:0] in_b_i,
  output logic             out_valid_o,
  input  logic             out_ready_i,
  output logic             res_lt_o,
  output logic             res_eq_o,
  output logic             res_gt_o,
  output logic [CNT_W-1:0] res_bits_o,
  output logic             busy_o
);
  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_e;
  state_e state_q, state_d;
  logic [WIDTH-1:0] sh_a_q, sh_a_d, sh_b_q, sh_b_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic eq_q, eq_d, lt_q, lt_d, gt_q, gt_d;
  logic bit_a, bit_b, last;
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= IDLE;
      sh_a_q <= '0;
      sh_b_q <= '0;
      cnt_q <= '0;
      eq_q <= 1'b1;
      lt_q <= 1'b0;
      gt_q <= 1'b0;
    end else begin
      state_q <= state_d;
      sh_a_q <= sh_a_d;
      sh_b_q <= sh_b_d;
      cnt_q <= cnt_d;
      eq_q <= eq_d;
      lt_q <= lt_d;
      gt_q <= gt_d;
    end
  end
  always_comb begin
    state_d = state_q;
    sh_a_d = sh_a_q;
    sh_b_d = sh_b_q;
    cnt_d = cnt_q;
    eq_d = eq_q;
    lt_d = lt_q;
    gt_d = gt_q;
    bit_a = sh_a_q[WIDTH-1];
    bit_b = sh_b_q[WIDTH-1];
    last = 1'b0;
    case (state_q)
      IDLE: if (in_valid_i) begin
        sh_a_d = in_a_i;
        sh_b_d = in_b_i;
        cnt_d = '0;
        eq_d = 1'b1;
        lt_d = 1'b0;
        gt_d = 1'b0;
        state_d = SHIFT;
      end
      SHIFT: begin
        // lt/gt can only be set while all more significant bits were equal
        eq_d = eq_q & (bit_a == bit_b);
        lt_d = lt_q | (eq_q & ~bit_a & bit_b);
        gt_d = gt_q | (eq_q & bit_a & ~bit_b);
        sh_a_d = sh_a_q << 1;
        sh_b_d = sh_b_q << 1;
        cnt_d = cnt_q + 1'b1;
`ifdef SERIAL_CMP_EARLY_EXIT_EN
        last = (cnt_d == CNT_W'(WIDTH)) | ~eq_d;
`else
        last = cnt_d == CNT_W'(WIDTH);
`endif
        if (last) state_d = DONE;
      end
      DONE: if (out_ready_i) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end
  assign in_ready_o = state_q == IDLE;
  assign busy_o = state_q != IDLE;
  assign out_valid_o = state_q == DONE;
  // core state is only meaningful as a result in DONE; eq resets to 1 so gating keeps res_* at 0 otherwise
  assign res_lt_o = out_valid_o & lt_q;
  assign res_eq_o = out_valid_o & eq_q;
  assign res_gt_o = out_valid_o & gt_q;
  assign res_bits_o = out_valid_o ? cnt_q : '0;
endmodule

// File: tb/tb_serial_compare_sequencer.sv
// tb_serial_compare_sequencer: directed and random checks of serial_compare_sequencer against a behavioural model
module tb_serial_compare_sequencer;
  localparam int W = 8;
  localparam int CW = $clog2(W + 1);
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic in_valid = 1'b0, in_ready, out_valid, out_ready = 1'b0;
  logic [W-1:0] in_a = '0, in_b = '0;
  logic res_lt, res_eq, res_gt, busy;
  logic [CW-1:0] res_bits;
  int n_cmp = 0, n_bad = 0;
  always #5 clk = ~clk;
  serial_compare_sequencer #(.WIDTH(W)) dut (
    .clk_i(clk), .rst_ni(rst_n),
    .in_valid_i(in_valid), .in_ready_o(in_ready),
    .in_a_i(in_a), .in_b_i(in_b),
    .out_valid_o(out_valid), .out_ready_i(out_ready),
    .res_lt_o(res_lt), .res_eq_o(res_eq), .res_gt_o(res_gt),
    .res_bits_o(res_bits), .busy_o(busy)
  );
  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask
  function automatic int ref_bits(input logic [W-1:0] a, input logic [W-1:0] b);
`ifdef SERIAL_CMP_EARLY_EXIT_EN
    for (int i = W - 1; i >= 0; i--) if (a[i] != b[i]) return W - i;
`endif
    return W;
  endfunction
  task automatic check_res(input string tag, input logic [W-1:0] a, input logic [W-1:0] b);
    check({tag, "_valid"}, out_valid, 1);
    check({tag, "_lt"}, res_lt, a < b);
    check({tag, "_eq"}, res_eq, a == b);
    check({tag, "_gt"}, res_gt, a > b);
    check({tag, "_bits"}, res_bits, ref_bits(a, b));
  endtask
  task automatic check_idle_outputs(input string tag);
    check({tag, "_valid"}, out_valid, 0);
    check({tag, "_res"}, {res_lt, res_eq, res_gt}, 0);
    check({tag, "_bits"}, res_bits, 0);
    check({tag, "_busy"}, busy, 0);
    check({tag, "_ready"}, in_ready, 1);
  endtask
  task automatic run_txn(input logic [W-1:0] a, input logic [W-1:0] b, input int stall);
    int k;
    @(negedge clk);
    check("acc_ready", in_ready, 1);
    in_valid = 1'b1;
    in_a = a;
    in_b = b;
    out_ready = 1'b0;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    in_a = W'($urandom);
    in_b = W'($urandom);
    k = 0;
    while (!out_valid && k < 200) begin
      @(posedge clk);
      #1;
      k++;
    end
    check("latency", k + 1, ref_bits(a, b) + 1);
    check_res("res", a, b);
    for (int s = 0; s < stall; s++) begin
      @(negedge clk);
      check("stall_ready", in_ready, 0);
      check_res("stall", a, b);
      in_valid = 1'b1;
      in_a = W'($urandom);
      in_b = W'($urandom);
      @(posedge clk);
      #1;
      in_valid = 1'b0;
    end
    @(negedge clk);
    check_res("pre_hs", a, b);
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    check("post_valid", out_valid, 0);
    check("post_ready", in_ready, 1);
  endtask
  task automatic run_b2b();
    logic [W-1:0] qa[3], qb[3];
    int acc_t[3];
    int ni, nr, t;
    logic acc, ov;
    ni = 0;
    nr = 0;
    for (int i = 0; i < 3; i++) begin
      qa[i] = W'($urandom);
      qb[i] = (i == 1) ? qa[i] : W'($urandom);
      acc_t[i] = 0;
    end
    @(negedge clk);
    in_a = qa[0];
    in_b = qb[0];
    in_valid = 1'b1;
    out_ready = 1'b1;
    for (t = 0; t < 300 && nr < 3; t++) begin
      acc = in_valid && in_ready;
      ov = out_valid;
      if (ov) begin
        check_res("b2b", qa[nr], qb[nr]);
        nr++;
      end
      @(posedge clk);
      #1;
      if (acc) begin
        acc_t[ni] = t;
        ni++;
        if (ni < 3) begin
          in_a = qa[ni];
          in_b = qb[ni];
        end else in_valid = 1'b0;
      end
      @(negedge clk);
    end
    in_valid = 1'b0;
    out_ready = 1'b0;
    check("b2b_count", nr, 3);
    check("b2b_gap0", acc_t[1] - acc_t[0], ref_bits(qa[0], qb[0]) + 2);
    check("b2b_gap1", acc_t[2] - acc_t[1], ref_bits(qa[1], qb[1]) + 2);
  endtask
  initial begin
    logic [W-1:0] a, b;
    repeat (3) @(posedge clk);
    #1;
    check_idle_outputs("reset");
    @(negedge clk);
    rst_n = 1'b1;
    run_txn(8'h80, 8'h7F, 0);
    run_txn(8'hA5, 8'hA5, 0);
    run_txn(8'h3C, 8'h3D, 5);
    @(negedge clk);
    in_valid = 1'b1;
    in_a = 8'h01;
    in_b = 8'h02;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    repeat (3) @(posedge clk);
    #2;
    check("abort_busy_before", busy, 1);
    rst_n = 1'b0;
    #1;
    check_idle_outputs("abort");
    @(negedge clk);
    rst_n = 1'b1;
    run_txn(8'h02, 8'h01, 0);
    run_b2b();
    for (int i = 0; i < 30; i++) begin
      a = W'($urandom);
      b = ($urandom_range(0, 3) == 0) ? a : W'($urandom);
      if ($urandom_range(0, 3) == 0) b = a ^ W'(1 << $urandom_range(0, W - 1));
      run_txn(a, b, $urandom_range(0, 2));
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
